// File: rtl/vgm_ahb_master.sv
// AHB-Lite single-transfer master.
// A request handshake feeds a two-slot pipeline: an address-phase slot (aph)
// and a data-phase slot (dph). Each transfer retires with a one-cycle response
// pulse. A two-cycle ERROR response cancels the pending address phase, which is
// then re-presented once the error has retired.
module vgm_ahb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // AHB-Lite master outputs
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  // AHB-Lite slave response
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b10
  } htrans_e;

  // address-phase slot; its address/control registers drive the bus directly
  logic              r_aph_valid;
  logic [ADDR_W-1:0] r_aph_addr;
  logic              r_aph_write;
  logic [2:0]        r_aph_size;
  logic [DATA_W-1:0] r_aph_wdata;
  // data-phase slot; write data lives in r_hwdata
  logic              r_dph_valid;
  logic              r_dph_write;
  logic [DATA_W-1:0] r_hwdata;
  // set between the first and second ERROR cycles
  logic              r_err_hold;
  htrans_e           r_htrans;
  // response registers
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  // next-state wires
  logic              w_accept;
  logic              w_advance;
  logic              w_err_first;
  logic              w_err_second;
  logic              w_retire;
  logic              w_aph_valid_n;
  logic              w_dph_valid_n;
  logic              w_dph_write_n;
  logic [DATA_W-1:0] w_hwdata_n;
  logic              w_err_hold_n;
  htrans_e           w_htrans_n;
  logic              w_rsp_err_n;
  logic [DATA_W-1:0] w_rsp_rdata_n;

  // No new request while an error is resolving or a stalled address phase is pending.
  assign req_ready = !r_err_hold && (!r_aph_valid || HREADY);
  assign w_accept  = req_valid && req_ready;

  assign HADDR     = r_aph_addr;
  assign HWRITE    = r_aph_write;
  assign HSIZE     = r_aph_size;
  assign HTRANS    = r_htrans;
  assign HBURST    = 3'b000;
  assign HWDATA    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Pipeline movement, error tracking and response formation for the coming edge.
  always_comb begin
    w_advance     = HREADY && !r_err_hold;
    w_err_first   = r_dph_valid && !r_err_hold && !HREADY && HRESP;
    w_err_second  = r_err_hold && HREADY;
    // With dph empty, HREADY/HRESP cannot retire anything.
    w_retire      = r_dph_valid && HREADY;

    w_aph_valid_n = r_aph_valid;
    w_dph_valid_n = r_dph_valid;
    w_dph_write_n = r_dph_write;
    w_hwdata_n    = r_hwdata;
    w_err_hold_n  = r_err_hold;
    w_htrans_n    = TR_IDLE;
    w_rsp_err_n   = 1'b0;
    w_rsp_rdata_n = {DATA_W{1'b0}};

    if (w_accept) begin
      w_aph_valid_n = 1'b1;
    end else if (w_advance) begin
      w_aph_valid_n = 1'b0;
    end else begin
      w_aph_valid_n = r_aph_valid;
    end

    if (w_advance) begin
      w_dph_valid_n = r_aph_valid;
      w_dph_write_n = r_aph_write;
      if (r_aph_valid && r_aph_write) begin
        w_hwdata_n = r_aph_wdata;
      end else begin
        w_hwdata_n = r_hwdata;
      end
    end else if (w_err_second) begin
      // errored transfer leaves dph; the retained aph does not advance
      w_dph_valid_n = 1'b0;
    end else begin
      w_dph_valid_n = r_dph_valid;
    end

    if (w_err_first) begin
      w_err_hold_n = 1'b1;
    end else if (w_err_second) begin
      w_err_hold_n = 1'b0;
    end else begin
      w_err_hold_n = r_err_hold;
    end

    if (w_aph_valid_n && !w_err_hold_n) begin
      w_htrans_n = TR_NONSEQ;
    end else begin
      w_htrans_n = TR_IDLE;
    end

    if (w_retire) begin
      w_rsp_err_n = r_err_hold || HRESP;
      if (r_dph_write) begin
        w_rsp_rdata_n = {DATA_W{1'b0}};
      end else begin
        w_rsp_rdata_n = HRDATA;
      end
    end else begin
      w_rsp_err_n   = 1'b0;
      w_rsp_rdata_n = {DATA_W{1'b0}};
    end
  end

  // State and output registers; reset discards all in-flight transfers silently.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_aph_valid <= 1'b0;
      r_aph_addr  <= {ADDR_W{1'b0}};
      r_aph_write <= 1'b0;
      r_aph_size  <= 3'b000;
      r_aph_wdata <= {DATA_W{1'b0}};
      r_dph_valid <= 1'b0;
      r_dph_write <= 1'b0;
      r_hwdata    <= {DATA_W{1'b0}};
      r_err_hold  <= 1'b0;
      r_htrans    <= TR_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_aph_addr  <= req_addr;
        r_aph_write <= req_write;
        r_aph_size  <= req_size;
        r_aph_wdata <= req_wdata;
      end
      r_aph_valid <= w_aph_valid_n;
      r_dph_valid <= w_dph_valid_n;
      r_dph_write <= w_dph_write_n;
      r_hwdata    <= w_hwdata_n;
      r_err_hold  <= w_err_hold_n;
      r_htrans    <= w_htrans_n;
      r_rsp_valid <= w_retire;
      r_rsp_rdata <= w_rsp_rdata_n;
      r_rsp_err   <= w_rsp_err_n;
    end
  end

endmodule

// File: doc/vgm_ahb_master.md
VGM_AHB_MASTER -- requirements
Module: vgm_ahb_master

Interface
REQ-001 Parameter ADDR_W, default 32, address width of req_addr and HADDR.
REQ-002 Parameter DATA_W, default 32, data width, legal values 32 or 64.
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous assertion, active-low.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-007 req_addr  input  ADDR_W  transfer address, size-aligned by the requester.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_size  input  3  HSIZE encoding, at most log2(DATA_W/8).
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-012 rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-013 rsp_err  output  1  transfer completed with ERROR response.
REQ-014 HADDR, HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HWDATA  outputs  AHB-Lite master address and data phase signals.
REQ-015 HRDATA  input  DATA_W; HREADY  input  1; HRESP  input  1  AHB-Lite slave response.

Function
REQ-016 The block SHALL issue single transfers only: HBURST constant 3'b000, HTRANS only IDLE (2'b00) or NONSEQ (2'b10).
REQ-017 The block SHALL hold one address-phase slot (aph) and one data-phase slot (dph), so at most 2 transfers are in flight.
REQ-018 A request accepted at edge N SHALL appear on HADDR/HWRITE/HSIZE with HTRANS=NONSEQ in cycle N+1; there is no combinational path from req_* to H* outputs.
REQ-019 req_ready SHALL be !err_hold && (!aph_valid || HREADY).
REQ-020 On an edge with HREADY=1 and err_hold=0: dph <= aph (empty if aph is empty); aph <= accepted request, otherwise empty.
REQ-021 While HREADY=0, the block SHALL hold aph, dph, HADDR, HWRITE, HSIZE, HTRANS and HWDATA stable, except as stated in REQ-023.
REQ-022 HWDATA SHALL equal dph write data while dph holds a write; otherwise it SHALL hold its last value.
REQ-023 On an edge with dph valid, HREADY=0 and HRESP=1 (first ERROR cycle), the block SHALL set err_hold, so that HTRANS=IDLE in the following cycle while aph contents are retained.
REQ-024 On an edge with err_hold=1 and HREADY=1 (second ERROR cycle): dph SHALL retire with rsp_err=1; aph SHALL NOT advance; err_hold SHALL clear; a retained aph transfer SHALL re-present as NONSEQ on the next cycle.
REQ-025 A dph transfer retiring on an edge with HREADY=1 SHALL produce rsp_valid=1 in the next cycle, with rsp_err=HRESP and rsp_rdata=HRDATA (reads) or 0 (writes), sampled at that edge.
REQ-026 Responses SHALL be in issue order, exactly one per accepted request.
REQ-027 HRESP=1 with HREADY=1 and no preceding first ERROR cycle SHALL be treated as a completion with rsp_err=1.
REQ-028 HREADY and HRESP SHALL be ignored when dph is empty; only HREADY gates aph advance then.
REQ-029 Back-to-back requests with HREADY=1 SHALL sustain one transfer per cycle.

Reset
REQ-030 While HRESETn=0: HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA=0; rsp_valid, rsp_rdata, rsp_err=0; aph, dph, err_hold empty/0; req_ready=1.
REQ-031 Reset mid-transfer SHALL discard aph and dph contents without any response; the first NONSEQ after release requires a new accepted request.

Verification
REQ-032 Write 0x100 data 0xA5A5A5A5 size 2, HREADY=1 -> NONSEQ at 0x100 in cycle 1, HWDATA=0xA5A5A5A5 in cycle 2, rsp_valid with rsp_err=0 in cycle 3.
REQ-033 Reads 0x0, 0x4, 0x8 back-to-back, HRDATA=0x11/0x22/0x33, HREADY=1 -> HTRANS NONSEQ 3 consecutive cycles; rsp_rdata 0x11, 0x22, 0x33 on consecutive cycles.
REQ-034 Read 0x10 then read 0x14, slave inserts 2 wait states on the first -> HADDR=0x14 stable for 3 cycles, req_ready=0 during waits, responses in order.
REQ-035 Read 0x20 then read 0x24, slave returns ERROR on 0x20 -> HTRANS=IDLE in the second ERROR cycle, rsp_err=1 for 0x20, 0x24 re-issued as NONSEQ and completes with rsp_err=0.
REQ-036 HRESETn pulsed low while a read is in dph with HREADY=0 -> all outputs at REQ-030 values, no rsp_valid after release, req_ready=1.
